regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_sb.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults for the scoreboarded register file
//
// Purpose: default geometry for regfile_sb and the fixed write-port count.
// Ports: none (package).
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NREAD_DEFAULT = 2;

    // Port 0 is the early/ALU port, port 1 the late/load port.
    localparam int NWR_PORTS = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for outstanding producers
//
// Purpose: tracks which registers have an issued but not yet written producer.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   wr_enable, wr_address    write strobes and destinations (clear busy)
//   issue_valid, issue_rd    issued instruction destination (sets busy)
//   busy                     one bit per register, bit 0 always 0
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NWR_PORTS-1:0]    wr_enable,
    input  logic [NWR_PORTS*AW-1:0] wr_address,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic [NREGS-1:0]        busy
);

    logic [NREGS-1:0] busy_next;

    // Clears are applied first and the set last, so a new producer issued in
    // the same cycle as the old producer's writeback keeps the register busy.
    always_comb begin
        busy_next = busy;
        for (int p = 0; p < NWR_PORTS; p++) begin
            if (wr_enable[p] && (wr_address[p*AW +: AW] != '0)) begin
                busy_next[wr_address[p*AW +: AW]] = 1'b0;
            end
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write, NREAD-read register file with busy scoreboard
//
// Purpose: architectural register file (x0 hardwired to zero) with optional
// same-cycle write forwarding and per-register producer tracking.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   wr_enable/address/data    two write ports, port 1 wins on collisions
//   rd_address, rd_data       NREAD combinational read ports
//   rd_busy                   source register still has an outstanding producer
//   issue_valid, issue_rd     destination of an instruction issued this cycle
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NREAD  = NREAD_DEFAULT,
    parameter int BYPASS = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NWR_PORTS-1:0]                 wr_enable,
    input  logic [NWR_PORTS*$clog2(NREGS)-1:0]   wr_address,
    input  logic [NWR_PORTS*XLEN-1:0]            wr_data,
    input  logic [NREAD*$clog2(NREGS)-1:0]       rd_address,
    output logic [NREAD*XLEN-1:0]                rd_data,
    output logic [NREAD-1:0]                     rd_busy,
    input  logic                                 issue_valid,
    input  logic [$clog2(NREGS)-1:0]             issue_rd
);

    localparam int AW       = $clog2(NREGS);
    localparam bit FORWARD  = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Later ports overwrite earlier ones through NBA ordering, giving port 1
    // priority on a same-address collision. Register 0 is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR_PORTS; p++) begin
                if (wr_enable[p] && (wr_address[p*AW +: AW] != '0)) begin
                    regs[wr_address[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .wr_enable   (wr_enable),
        .wr_address  (wr_address),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] fwd;

        assign addr = rd_address[k*AW +: AW];

        // Scan ports in ascending order so the highest-numbered matching
        // port is the one forwarded.
        always_comb begin
            hit = 1'b0;
            fwd = '0;
            for (int p = 0; p < NWR_PORTS; p++) begin
                if (FORWARD && wr_enable[p] && (wr_address[p*AW +: AW] == addr)) begin
                    hit = 1'b1;
                    fwd = wr_data[p*XLEN +: XLEN];
                end
            end
        end

        // Gating on reset keeps forwarded write data off the outputs while
        // the array itself is being cleared.
        always_comb begin
            if (reset || (addr == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end else if (hit) begin
                rd_data[k*XLEN +: XLEN] = fwd;
                rd_busy[k]              = 1'b0;
            end else begin
                rd_data[k*XLEN +: XLEN] = regs[addr];
                rd_busy[k]              = busy[addr];
            end
        end
    end

endmodule
